// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator with valid/ready issue and buffered redirects.
// Optional misaligned-fetch flag enabled by defining PC_ALIGN_CHECK_EN.
module pc_gen #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'hbfc00000),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'hbfc00380),
    parameter int               INC       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             exc_valid,
    input  logic             eret_valid,
    input  logic [WIDTH-1:0] eret_target,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    input  logic             fetch_ready,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] pc,
    output logic             pend_valid,
    output logic             adel
);

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_BLOCKED,
        S_PEND
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pend_tgt;
    logic             redir;
    logic [WIDTH-1:0] redir_tgt;
    logic             accept;
    logic [WIDTH-1:0] pc_nxt;
    logic             fv_nxt;
    logic             pv_nxt;
    logic [WIDTH-1:0] pt_nxt;

    assign redir  = exc_valid | eret_valid | br_valid;
    assign accept = fetch_valid & fetch_ready;

    always_comb begin
        redir_tgt = br_target;
        if (exc_valid)
            redir_tgt = EXC_VEC;
        else if (eret_valid)
            redir_tgt = eret_target;
    end

    // Blocked takes precedence: a stalled request must keep its address even with a redirect buffered.
    always_comb begin
        state = S_IDLE;
        if (fetch_valid && !fetch_ready)
            state = S_BLOCKED;
        else if (pend_valid)
            state = S_PEND;
        else if (fetch_valid)
            state = S_REQ;
    end

    always_comb begin
        pc_nxt = pc;
        fv_nxt = fetch_valid;
        pv_nxt = pend_valid;
        pt_nxt = pend_tgt;
        case (state)
            S_BLOCKED: begin
                if (redir) begin
                    pv_nxt = 1'b1;
                    pt_nxt = redir_tgt;
                end
            end
            default: begin
                if (redir)
                    pc_nxt = redir_tgt;
                else if (state == S_PEND)
                    pc_nxt = pend_tgt;
                else if (accept)
                    pc_nxt = pc + INC_W;
                pv_nxt = 1'b0;
                fv_nxt = en;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_VEC;
            fetch_valid <= 1'b0;
            pend_valid  <= 1'b0;
            pend_tgt    <= '0;
        end else begin
            pc          <= pc_nxt;
            fetch_valid <= fv_nxt;
            pend_valid  <= pv_nxt;
            pend_tgt    <= pt_nxt;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic adel_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            adel_q <= 1'b0;
        else
            adel_q <= |pc_nxt[1:0];
    end

    assign adel = adel_q;
`else
    assign adel = 1'b0;
`endif

endmodule
